// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field widths per operand width, FSM states,
// canonical NaN and operand classification helpers.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [63:0] QNAN_64 = 64'h7FF8_0000_0000_0000;

  function automatic int unsigned fp_exp_w(input int unsigned n);
    return (n == 64) ? 11 : 8;
  endfunction

  function automatic int unsigned fp_man_w(input int unsigned n);
    return (n == 64) ? 52 : 23;
  endfunction

  function automatic int unsigned fp_bias(input int unsigned n);
    return (n == 64) ? 1023 : 127;
  endfunction

  // Classification works on reduced field flags so it is independent of N.
  function automatic logic is_nan(input logic exp_ones, input logic frac_nz);
    return exp_ones & frac_nz;
  endfunction

  function automatic logic is_inf(input logic exp_ones, input logic frac_nz);
    return exp_ones & ~frac_nz;
  endfunction

  // Subnormals count as zero: the multiplier flushes them.
  function automatic logic is_zero(input logic exp_zero);
    return exp_zero;
  endfunction

endpackage

// File: rtl/cseladd.sv
// Carry-select adder: low half ripples, high half is precomputed for both
// carry-in values and selected by the low-half carry.
module cseladd #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  localparam int unsigned LO = W / 2;
  localparam int unsigned HI = W - LO;

  logic [LO:0]   lo_sum;
  logic [HI-1:0] hi_sum0;
  logic [HI-1:0] hi_sum1;

  assign lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
  assign hi_sum0 = a[W-1:LO] + b[W-1:LO];
  assign hi_sum1 = a[W-1:LO] + b[W-1:LO] + HI'(1);
  assign sum     = {(lo_sum[LO] ? hi_sum1 : hi_sum0), lo_sum[LO-1:0]};

endmodule

// File: rtl/fmul_seq.sv
// Sequential IEEE-754 multiplier: one multiplier bit per cycle shift-add,
// then a single normalize/round-to-nearest-even cycle, valid/ready on both sides.
module fmul_seq
  import fp_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         busy
);

  localparam int unsigned EXP_W = fp_exp_w(N);
  localparam int unsigned MAN_W = fp_man_w(N);
  localparam int unsigned BIAS  = fp_bias(N);
  localparam int unsigned M     = MAN_W + 1;
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned CW    = $clog2(M);

  localparam logic [CW-1:0]        CNT_LAST = CW'(MAN_W);
  localparam logic signed [EW-1:0] E_MAX    = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO   = '0;
  localparam logic [N-1:0]         QNAN_N   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t state, state_nxt;

  logic             sign_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [M-1:0]     ma_q, mb_q;
  logic [2*M-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     result_q;

  // Operand classification at the input port
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sign_in;
  logic             special;
  logic [N-1:0]     special_res;

  assign a_exp   = a[N-2:MAN_W];
  assign b_exp   = b[N-2:MAN_W];
  assign a_frac  = a[MAN_W-1:0];
  assign b_frac  = b[MAN_W-1:0];
  assign a_nan   = is_nan(&a_exp, |a_frac);
  assign b_nan   = is_nan(&b_exp, |b_frac);
  assign a_inf   = is_inf(&a_exp, |a_frac);
  assign b_inf   = is_inf(&b_exp, |b_frac);
  assign a_zero  = is_zero(~|a_exp);
  assign b_zero  = is_zero(~|b_exp);
  assign sign_in = a[N-1] ^ b[N-1];

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      special_res = QNAN_N;
    end else if (a_inf || b_inf) begin
      special_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      special_res = {sign_in, {(N-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Normalize and round from the finished accumulator
  logic             norm;
  logic [MAN_W-1:0] frac_sel;
  logic             guard, sticky, round_up;
  logic [MAN_W:0]   frac_sum;
  logic             rnd_carry;
  logic [EW-1:0]    exp_sum;
  logic signed [EW-1:0] e_res;
  logic [N-1:0]     norm_res;

  assign norm     = acc_q[2*M-1];
  assign frac_sel = norm ? acc_q[2*M-2:M] : acc_q[2*M-3:M-1];
  assign guard    = norm ? acc_q[M-1] : acc_q[M-2];
  assign sticky   = norm ? |acc_q[M-2:0] : |acc_q[M-3:0];
  assign round_up = guard & (sticky | frac_sel[0]);

  // The hidden bit is always 1, so a carry out of the fraction is a mantissa overflow;
  // the wrapped fraction is then already zero.
  assign frac_sum  = {1'b0, frac_sel} + {{MAN_W{1'b0}}, round_up};
  assign rnd_carry = frac_sum[MAN_W];

  cseladd #(.W(EW)) u_exp_add (
    .a   ({2'b00, ea_q}),
    .b   ({2'b00, eb_q}),
    .cin (norm),
    .sum (exp_sum)
  );

  assign e_res = $signed(exp_sum + {{(EW-1){1'b0}}, rnd_carry} - EW'(BIAS));

  always_comb begin
    if (e_res >= E_MAX) begin
      norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_res <= E_ZERO) begin
      norm_res = {sign_q, {(N-1){1'b0}}};
    end else begin
      norm_res = {sign_q, e_res[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = special ? DONE : MUL;
      MUL:  if (cnt_q == CNT_LAST) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sign_in;
            ea_q   <= a_exp;
            eb_q   <= b_exp;
            ma_q   <= {1'b1, a_frac};
            mb_q   <= {1'b1, b_frac};
            acc_q  <= '0;
            cnt_q  <= '0;
            if (special) result_q <= special_res;
          end
        end
        MUL: begin
          if (mb_q[cnt_q]) acc_q <= acc_q + ({{M{1'b0}}, ma_q} << cnt_q);
          cnt_q <= cnt_q + CW'(1);
        end
        NORM: result_q <= norm_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;

endmodule
